// File: rtl/rf_sequencer.sv
// rf_sequencer: 4-state client of the 4x9 register file.
// Accepts an instruction, reads operands, runs the ALU, writes back.
module rf_sequencer #(
   parameter int DW = 9,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_instr,
   input  logic [DW-1:0] in_imm,
   output logic [AW-1:0] rd0_addr,
   output logic [AW-1:0] rd1_addr,
   input  logic [DW-1:0] rd0_data,
   input  logic [DW-1:0] rd1_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          z_flag,
   output logic          c_flag,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE
   } state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_MOV = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_OUT = 3'b111;

   state_t        r_state;
   state_t        w_nxt;
   logic [2:0]    r_op;
   logic [AW-1:0] r_rd;
   logic [DW-1:0] r_imm;
   logic [AW-1:0] r_rd0_addr;
   logic [AW-1:0] r_rd1_addr;
   logic [DW-1:0] r_op0;
   logic [DW-1:0] r_op1;
   logic [DW-1:0] r_result;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic [DW-1:0] r_wr_data;
   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic          r_z;
   logic          r_c;

   logic [DW:0]   w_sum;
   logic [DW-1:0] w_res;
   logic          w_c;
   logic          w_upd;
   logic          w_we;

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rd0_addr  = r_rd0_addr;
   assign rd1_addr  = r_rd1_addr;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign z_flag    = r_z;
   assign c_flag    = r_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nxt;
   end

   // Next-state: fixed 4-cycle walk once an instruction is taken
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_nxt = S_READ;
         S_READ:  w_nxt = S_EXEC;
         S_EXEC:  w_nxt = S_WRITE;
         S_WRITE: w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // ALU on the latched operands; also decides write-back and flag update
   always_comb begin
      w_sum = {1'b0, r_op0} + {1'b0, r_op1};
      w_res = '0;
      w_c   = 1'b0;
      w_upd = 1'b0;
      w_we  = 1'b0;
      case (r_op)
         OP_LDI: begin w_res = r_imm; w_we = 1'b1; end
         OP_MOV: begin w_res = r_op0; w_we = 1'b1; end
         OP_ADD: begin
            w_res = w_sum[DW-1:0];
            w_c   = w_sum[DW];
            w_upd = 1'b1;
            w_we  = 1'b1;
         end
         OP_SUB: begin
            w_res = r_op0 - r_op1;
            w_c   = (r_op0 < r_op1);
            w_upd = 1'b1;
            w_we  = 1'b1;
         end
         OP_AND: begin w_res = r_op0 & r_op1; w_upd = 1'b1; w_we = 1'b1; end
         OP_XOR: begin w_res = r_op0 ^ r_op1; w_upd = 1'b1; w_we = 1'b1; end
         default: w_res = '0;
      endcase
   end

   // Datapath registers; write/out strobes are one-cycle pulses in WRITE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op        <= OP_NOP;
         r_rd        <= '0;
         r_imm       <= '0;
         r_rd0_addr  <= '0;
         r_rd1_addr  <= '0;
         r_op0       <= '0;
         r_op1       <= '0;
         r_result    <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
      end else begin
         r_wr_en     <= 1'b0;
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_op       <= in_instr[8:6];
               r_rd       <= in_instr[5:4];
               r_imm      <= in_imm;
               r_rd0_addr <= in_instr[3:2];
               r_rd1_addr <= in_instr[1:0];
            end
            S_READ: begin
               r_op0 <= rd0_data;
               r_op1 <= rd1_data;
            end
            S_EXEC: begin
               r_result <= w_res;
               if (w_upd) begin
                  r_z <= (w_res == '0);
                  r_c <= w_c;
               end
               if (w_we) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_rd;
                  r_wr_data <= w_res;
               end
               if (r_op == OP_OUT) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_op0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: directed bench with a behavioural 4x9 register file.
// Expected values are hand-computed constants.
module tb_rf_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_instr;
   logic [8:0] in_imm;
   logic [1:0] rd0_addr;
   logic [1:0] rd1_addr;
   logic [8:0] rd0_data;
   logic [8:0] rd1_data;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [8:0] wr_data;
   logic       out_valid;
   logic [8:0] out_data;
   logic       z_flag;
   logic       c_flag;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int wr_cnt  = 0;
   int acc_q[$];

   logic [8:0] rf [4];

   rf_sequencer #(.DW(9), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_imm(in_imm),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
      .rd0_data(rd0_data), .rd1_data(rd1_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .out_valid(out_valid), .out_data(out_data),
      .z_flag(z_flag), .c_flag(c_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   // Register file model: async reads, write on falling edge
   assign rd0_data = rf[rd0_addr];
   assign rd1_data = rf[rd1_addr];
   always @(negedge clk) begin
      if (wr_en) begin
         rf[wr_addr] <= wr_data;
         wr_cnt++;
      end
   end

   // Cycle counter and accept log
   always @(posedge clk) begin
      cyc++;
      if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction and check every cycle of its 4-cycle walk
   task automatic run(input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input logic [8:0] imm, input bit we, input bit ov,
                      input logic [8:0] exp);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk("ready_wait", (n < 20), 1);
      in_valid = 1'b1;
      in_instr = {op, rd, rs1, rs2};
      in_imm   = imm;
      step();
      in_valid = 1'b0;
      in_instr = 9'h1ff;
      in_imm   = 9'h1ff;
      chk("read_busy", busy, 1);
      chk("read_rdy", in_ready, 0);
      chk("read_a0", rd0_addr, rs1);
      chk("read_a1", rd1_addr, rs2);
      chk("read_we", wr_en, 0);
      step();
      chk("exec_we", wr_en, 0);
      chk("exec_ov", out_valid, 0);
      chk("exec_rdy", in_ready, 0);
      step();
      chk("wr_we", wr_en, we);
      chk("wr_ov", out_valid, ov);
      chk("wr_rdy", in_ready, 0);
      if (we) begin
         chk("wr_addr", wr_addr, rd);
         chk("wr_data", wr_data, exp);
      end
      if (ov) chk("out_data", out_data, exp);
      step();
      chk("done_we", wr_en, 0);
      chk("done_ov", out_valid, 0);
      chk("done_rdy", in_ready, 1);
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 4; i++) rf[i] = '0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_instr = '0;
      in_imm   = '0;
      step();
      step();
      rst = 1'b0;
      step();

      chk("rst_rdy", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", wr_en, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_z", z_flag, 0);
      chk("rst_c", c_flag, 0);
      chk("rst_wd", wr_data, 0);
      chk("rst_od", out_data, 0);

      // LDI r1,13
      run(3'b001, 2'd1, 2'd0, 2'd0, 9'd13, 1, 0, 9'd13);
      chk("r1_13", rf[1], 13);

      // LDI r0,117; ADD r2,r0,r1; OUT r2
      run(3'b001, 2'd0, 2'd0, 2'd0, 9'd117, 1, 0, 9'd117);
      run(3'b011, 2'd2, 2'd0, 2'd1, 9'd0, 1, 0, 9'd130);
      chk("add1_z", z_flag, 0);
      chk("add1_c", c_flag, 0);
      w0 = wr_cnt;
      run(3'b111, 2'd0, 2'd2, 2'd0, 9'd0, 0, 1, 9'd130);
      chk("out_nowr", wr_cnt - w0, 0);

      // Carry / borrow / zero
      run(3'b001, 2'd0, 2'd0, 2'd0, 9'd500, 1, 0, 9'd500);
      run(3'b001, 2'd1, 2'd0, 2'd0, 9'd20, 1, 0, 9'd20);
      run(3'b011, 2'd3, 2'd0, 2'd1, 9'd0, 1, 0, 9'd8);
      chk("add2_c", c_flag, 1);
      chk("add2_z", z_flag, 0);
      run(3'b100, 2'd2, 2'd1, 2'd0, 9'd0, 1, 0, 9'd32);
      chk("sub_c", c_flag, 1);
      chk("sub_z", z_flag, 0);
      run(3'b110, 2'd2, 2'd2, 2'd2, 9'd0, 1, 0, 9'd0);
      chk("xor_z", z_flag, 1);
      chk("xor_c", c_flag, 0);

      // NOP and OUT leave flags and registers alone
      w0 = wr_cnt;
      run(3'b000, 2'd3, 2'd0, 2'd0, 9'd99, 0, 0, 9'd0);
      run(3'b111, 2'd0, 2'd3, 2'd0, 9'd0, 0, 1, 9'd8);
      chk("nop_nowr", wr_cnt - w0, 0);
      chk("nop_z", z_flag, 1);
      chk("nop_c", c_flag, 0);
      chk("r3_8", rf[3], 8);

      // Back-to-back dependency, valid held high
      acc_q.delete();
      in_valid = 1'b1;
      in_instr = {3'b001, 2'd1, 2'd0, 2'd0};
      in_imm   = 9'd7;
      step();
      in_instr = {3'b010, 2'd2, 2'd1, 2'd0};
      in_imm   = 9'd0;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_rdy_lo", in_ready, 0);
         step();
      end
      chk("b2b_rdy_hi", in_ready, 1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("b2b_nacc", acc_q.size(), 2);
      if (acc_q.size() == 2)
         chk("b2b_gap", acc_q[1] - acc_q[0], 4);
      chk("b2b_r1", rf[1], 7);
      chk("b2b_r2", rf[2], 7);

      // AND r0,r1,r2 = 7
      run(3'b101, 2'd0, 2'd1, 2'd2, 9'd0, 1, 0, 9'd7);
      chk("and_z", z_flag, 0);
      chk("and_c", c_flag, 0);

      // Reset during EXEC of ADD r3,r1,r2
      w0 = wr_cnt;
      in_valid = 1'b1;
      in_instr = {3'b011, 2'd3, 2'd1, 2'd2};
      step();
      in_valid = 1'b0;
      step();
      chk("pre_rst_busy", busy, 1);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_instr = {3'b001, 2'd0, 2'd0, 2'd0};
      in_imm   = 9'd5;
      step();
      chk("mr_we", wr_en, 0);
      chk("mr_ov", out_valid, 0);
      chk("mr_rdy", in_ready, 1);
      chk("mr_busy", busy, 0);
      chk("mr_wa", wr_addr, 0);
      chk("mr_wd", wr_data, 0);
      chk("mr_od", out_data, 0);
      chk("mr_a0", rd0_addr, 0);
      chk("mr_a1", rd1_addr, 0);
      chk("mr_z", z_flag, 0);
      step();
      chk("mr_busy2", busy, 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("mr_nowr", wr_cnt - w0, 0);
      chk("mr_r3", rf[3], 8);
      chk("mr_r0", rf[0], 7);
      chk("mr_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rf_sequencer.md
Name: rf_sequencer

Overview:
- Initiator/client side of the 4x9-bit register-file interface: 2 async-read ports, 1 write port sampled by the register file on the clock falling edge.
- Accepts 9-bit instructions over a valid/ready handshake, reads operands from the register file, executes a small ALU operation, and writes the result back.
- Sits between an instruction source (test stimulus or future fetch unit) and the register file. Forms the core of the 9-bit datapath.

Parameters:
- DW, 9, data width; must match register-file data width.
- AW, 2, register address width (4 registers).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- in_valid  input  1  instruction present on in_instr/in_imm.
- in_ready  output  1  block can accept an instruction (high only in IDLE).
- in_instr  input  9  [8:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2.
- in_imm  input  9  immediate for LDI; ignored otherwise.
- rd0_addr  output  2  register-file read port 0 address (rs1).
- rd1_addr  output  2  register-file read port 1 address (rs2).
- rd0_data  input  9  register-file read data 0 (combinational from rd0_addr).
- rd1_data  input  9  register-file read data 1.
- wr_en  output  1  register-file write enable.
- wr_addr  output  2  register-file write address.
- wr_data  output  9  register-file write data.
- out_valid  output  1  one-cycle pulse; out_data valid (OUT opcode).
- out_data  output  9  value of rs1 for OUT.
- z_flag  output  1  zero flag of last ALU op.
- c_flag  output  1  carry (ADD) / borrow (SUB) of last ALU op.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Opcodes:
  - 000 NOP: no write.
  - 001 LDI: rd <= in_imm.
  - 010 MOV: rd <= rs1.
  - 011 ADD: rd <= rs1+rs2.
  - 100 SUB: rd <= rs1-rs2.
  - 101 AND.
  - 110 XOR.
  - 111 OUT: out_data <= rs1, no write.
- Arithmetic mod 2^9.
  - ADD: c = bit 9 of the 10-bit sum.
  - SUB: c = 1 when rs1 < rs2 (unsigned borrow).
  - AND/XOR: c = 0.
  - z = (9-bit result == 0).
- Flags update only for ADD/SUB/AND/XOR; hold otherwise.
- FSM states: IDLE, READ, EXEC, WRITE. Every instruction traverses all four.
  - IDLE: in_ready=1. On posedge with in_valid=1: latch opcode, rd, imm; rd0_addr<=rs1, rd1_addr<=rs2; go to READ. With in_valid=0: stay.
  - READ: addresses stable for a full cycle. On posedge: latch rd0_data/rd1_data into operand registers; go to EXEC.
  - EXEC: on posedge: compute result into result register, update flags; go to WRITE.
  - WRITE: on the same entering posedge, wr_en<=1 for LDI/MOV/ADD/SUB/AND/XOR, with wr_addr=rd and wr_data=result. For OUT: out_valid<=1, out_data<=operand0. For NOP: nothing. Next posedge: wr_en/out_valid return to 0; go to IDLE.
- wr_en and out_valid are high for exactly one cycle (the WRITE cycle). The register file commits on that cycle's falling edge.
- Throughput: one instruction per 4 cycles. in_ready is combinational from state (IDLE only). Acceptance requires in_valid && in_ready at posedge.
- Back-to-back dependency (write then read of the same register) needs no stall. The write commits mid-WRITE; the next instruction's READ is at least 2 cycles later.
- in_instr/in_imm are don't-care outside the accepting edge.
- Reset (synchronous, overrides everything, including mid-instruction):
  - State -> IDLE.
  - rd0_addr = rd1_addr = wr_addr = 0, wr_data = 0, wr_en = 0, out_valid = 0, out_data = 0, z_flag = 0, c_flag = 0.
  - Operand/result registers = 0.
  - An in-flight instruction is dropped with no write.
  - An instruction presented during reset is not accepted.

Test Plan:
- Reset then LDI r1,13 -> wr_en high for 1 cycle exactly 3 cycles after accept, wr_addr=01, wr_data=000001101; in_ready returns at cycle 4.
- LDI r0,117; LDI r1,13; ADD r2,r0,r1; OUT r2 -> out_valid pulse with out_data=130, z=0, c=0.
- LDI r0,500; LDI r1,20; ADD r3,r0,r1 -> r3=8, c_flag=1, z_flag=0. Then SUB r2,r1,r0 -> r2=32, c_flag=1. Then XOR r2,r2,r2 -> r2=0, z_flag=1, c_flag=0.
- Back-to-back dependency: LDI r1,7 then MOV r2,r1 held valid continuously -> r2=7. in_ready low 3 cycles per instruction, second accept exactly 4 cycles after first.
- Assert rst during EXEC of ADD r3 -> wr_en never asserts, r3 unchanged, all outputs at reset values the next cycle, in_ready=1.
- NOP and OUT -> wr_en stays 0 throughout. Flags unchanged from the prior ALU op.
